// File: rtl/dda_sample_fifo.sv
// Decimating capture stage for the dda integrator: keeps one (t, y) sample per DECIM steps
// in a first-word-fall-through FIFO and counts samples lost while the buffer is full.
module dda_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int DECIM = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           t_in,
    input  logic [WIDTH-1:0]           y_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_t,
    output logic [WIDTH-1:0]           out_y,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                dropped,
    input  logic                       clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [DW-1:0]          dcnt;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [2*WIDTH-1:0]     mem [DEPTH];

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // out_valid comes from the registered count only, never from out_ready
    assign out_valid = (count != '0);
    assign full      = (count == COUNT_FULL);
    assign capture   = in_valid && (dcnt == DCNT_LAST);
    assign pop       = out_valid && out_ready;
    assign push      = capture && (!full || pop);
    assign drop      = capture && full && !pop;

    assign out_t = mem[rd_ptr][2*WIDTH-1:WIDTH];
    assign out_y = mem[rd_ptr][WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {t_in, y_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dcnt     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
        end else begin
            if (in_valid) begin
                dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // a clear wins over a drop landing on the same edge
            if (clear_ovf) begin
                overflow <= 1'b0;
                dropped  <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (dropped != 16'hFFFF) begin
                    dropped <= dropped + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dda_sample_fifo.md
# dda_sample_fifo

Downstream capture stage for the `dda` integrator. Decimates the per-step (t, y) Q16.16 stream and buffers samples in a small first-word-fall-through FIFO. Offers them to a consumer (logger/UART bridge) over a valid/ready handshake. Detects and counts samples dropped while the buffer is full.

## Interface
- `WIDTH`, 32: data width of t and y (Q16.16).
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DECIM`, 64: one sample kept per DECIM integrator steps; ≥1.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted at 0).
- `in_valid` input 1: high for each cycle in which the integrator takes a step.
- `t_in` input WIDTH: integrator time.
- `y_in` input WIDTH: integrator state.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts head entry.
- `out_t` output WIDTH: head-entry t.
- `out_y` output WIDTH: head-entry y.
- `count` output $clog2(DEPTH)+1: entries held, 0..DEPTH.
- `overflow` output 1: sticky; a decimated sample was dropped.
- `dropped` output 16: number of dropped samples, saturating at 16'hFFFF.
- `clear_ovf` input 1: synchronous clear of `overflow` and `dropped`.

## Operation
- Decimation counter `dcnt` (0..DECIM-1), reset 0, advances only on `in_valid`.
  - At `dcnt==DECIM-1`: it wraps to 0 and the current `t_in`/`y_in` become a capture.
  - Otherwise `dcnt` increments.
  - With DECIM=1, every `in_valid` is a capture.
- Push = capture accepted. Pop = `out_valid && out_ready`.
- A capture is accepted when `count<DEPTH` or a pop occurs in the same cycle. Full plus simultaneous pop therefore accepts the capture; `count` stays DEPTH.
- A rejected capture leaves the FIFO unchanged, sets `overflow`, and increments `dropped` (saturating).
- `count` update per edge:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Head output comes from the storage array at the read pointer (FWFT).
- `out_t`/`out_y` are don't-care while `out_valid=0`. The bench must not check them then.
- `out_ready` while empty has no effect.
- `clear_ovf` takes priority over a same-cycle drop: both `overflow` and `dropped` become 0 at the next edge.
- No arithmetic is performed on samples; data is stored bit-exact.

## Timing
- Reset (`reset`=0, asynchronous) forces, without waiting for a clock edge:
  - `out_valid`=0, `count`=0, `overflow`=0, `dropped`=0.
  - `dcnt`=0 and both pointers 0.
- Storage contents are not reset.
- Reset may be asserted mid-run. Buffered samples are discarded, and decimation restarts from 0 after release.
- Deassertion is treated as synchronous by the system; the first active edge follows.
- Capture latency: a capture at edge k gives `out_valid`=1 and head data visible after edge k when the FIFO was empty. That is one cycle from the `in_valid` cycle.
- Pop at edge k: the next entry, or `out_valid`=0, is visible after edge k.
- Sustained throughput: one push and one pop per cycle.
- `out_valid` must not depend combinationally on `out_ready`.
- `out_t`/`out_y` hold stable while `out_valid`=1 and `out_ready`=0.
- `overflow`/`dropped` update at the edge of the rejected capture.

## Test plan
- Reset defaults: DEPTH=4, DECIM=4; hold `reset`=0, then release. Required after release and before any `in_valid`: `out_valid`=0, `count`=0, `overflow`=0, `dropped`=0.
- Decimation: `in_valid`=1 continuously with `t_in`=n·128 and `y_in`=65536+n for n=0,1,2,…, and `out_ready`=1. Required:
  - The first `out_valid` appears after the n=3 edge with `out_t`=384 and `out_y`=65539.
  - The next sample is `out_t`=896, `out_y`=65543.
  - Exactly one pop occurs per 4 steps.
- Fill/overflow: same stimulus with `out_ready`=0 for 20 steps. Required:
  - `count` reaches 4 after n=15.
  - The capture at n=19 is dropped, giving `overflow`=1 and `dropped`=1.
  - The head stays `out_t`=384 throughout.
- Full with simultaneous pop: FIFO full, `out_ready`=1 on a capture cycle. Required:
  - `count` stays 4 and `overflow` is unchanged.
  - The new sample appears as the 4th entry after the remaining three drain.
- Clear priority: with `overflow`=1, assert `clear_ovf` in the same cycle as another drop. Required: `overflow`=0 and `dropped`=0 next cycle.
- Async reset mid-run: pull `reset` low between clock edges while `count`=3. Required:
  - `out_valid`=0 and `count`=0 immediately, before the next edge.
  - After release, the first capture occurs again on the 4th `in_valid`.
